// File: rtl/adder_sequencer.sv
// Nibble-serial adder: one 4-bit slice is reused over NIB cycles to form a W-bit sum.
// state | meaning
// IDLE  | waiting for an operation (in_ready high)
// RUN   | one nibble added per cycle, idx selects the nibble
// DONE  | result presented until out_ready
module adder_sequencer #(
   parameter int NIB = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NIB-1:0]  in_a,
   input  logic [4*NIB-1:0]  in_b,
   input  logic              in_cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NIB-1:0]  out_sum,
   output logic              out_carry,
   output logic              busy
);

   localparam int W  = 4 * NIB;
   localparam int IW = $clog2(NIB);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic [IW-1:0]   idx_q, idx_d;

   logic [3:0]      nib_a, nib_b, nib_s;
   logic            nib_c;

   assign nib_a = a_q[4*idx_q +: 4];
   assign nib_b = b_q[4*idx_q +: 4];
   assign {nib_c, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[4*idx_q +: 4] = nib_s;
            carry_d             = nib_c;
            if (idx_q == IW'(NIB - 1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
      end
   end

   // Operands are only read after an accept has loaded them, so no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_sum   = sum_q;
   assign out_carry = carry_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: directed vectors plus random traffic against a queue-based sum model.
module tb_adder_sequencer;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_carry;
   logic          busy;

   adder_sequencer #(.NIB(NIB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [W:0]    exp_q[$];
   int            res_cyc[$];
   int            cyc       = 0;
   int            acc_cnt   = 0;
   int            res_cnt   = 0;
   int            dropped   = 0;
   int            acc_cyc   = 0;
   bit            pending   = 0;
   bit            prev_ov   = 0;
   bit            rand_ready = 0;
   logic [W-1:0]  hold_sum;
   logic          hold_cy;
   logic [W-1:0]  last_sum;
   logic          last_carry;

   // Observer: sums are predicted at accept time and retired in order at each result handshake.
   initial begin
      logic [W:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            dropped += exp_q.size();
            exp_q.delete();
            pending = 0;
         end else begin
            check("excl", 64'(in_ready & out_valid), 64'd0);
            check("busy", 64'(busy), 64'(!in_ready));
            if (pending) check("ready_low", 64'(in_ready), 64'd0);
            if (out_valid) begin
               if (exp_q.size() == 0) check("spurious", 64'(out_valid), 64'd0);
               if (!prev_ov) begin
                  check("latency", 64'(cyc - acc_cyc), 64'(NIB + 1));
               end else begin
                  check("hold_sum", 64'(out_sum), 64'(hold_sum));
                  check("hold_cy", 64'(out_carry), 64'(hold_cy));
               end
               hold_sum = out_sum;
               hold_cy  = out_carry;
               if (out_ready && exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("sum", 64'(out_sum), 64'(e[W-1:0]));
                  check("carry", 64'(out_carry), 64'(e[W]));
                  last_sum   = out_sum;
                  last_carry = out_carry;
                  res_cnt++;
                  res_cyc.push_back(cyc);
                  pending = 0;
               end
            end
            if (in_valid && in_ready) begin
               check("overlap", 64'(exp_q.size()), 64'd0);
               e = {1'b0, in_a} + {1'b0, in_b} + (W+1)'(in_cin);
               exp_q.push_back(e);
               acc_cnt++;
               acc_cyc = cyc;
               pending = 1;
            end
         end
         prev_ov = rst ? 1'b0 : out_valid;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit keep);
      int start;
      bit ok;
      start = acc_cnt;
      ok = 0;
      in_a = a;
      in_b = b;
      in_cin = c;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt != start) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 64'(acc_cnt), 64'(start + 1));
      if (!keep) begin
         // Scramble inputs after the accept; the operation in flight must not see them.
         in_valid = 1'b0;
         in_a = W'($urandom);
         in_b = W'($urandom);
         in_cin = 1'($urandom);
      end
   endtask

   task automatic wait_results(input int target);
      for (int i = 0; i < 100; i++) begin
         if (res_cnt >= target) break;
         @(posedge clk);
         #1;
      end
      if (res_cnt < target) check("res_timeout", 64'(res_cnt), 64'(target));
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0, r0, n;
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_cin = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(out_sum), 64'd0);
      check("rst_carry", 64'(out_carry), 64'd0);

      out_ready = 1'b1;
      drive_op(16'hFFFF, 16'h0001, 1'b0, 0);
      wait_results(res_cnt + 1);
      check("ffff_sum", 64'(last_sum), 64'h0000);
      check("ffff_carry", 64'(last_carry), 64'd1);

      drive_op(16'h1234, 16'h4321, 1'b1, 0);
      wait_results(res_cnt + 1);
      check("1234_sum", 64'(last_sum), 64'h5556);
      check("1234_carry", 64'(last_carry), 64'd0);

      out_ready = 1'b0;
      drive_op(16'hABCD, 16'h1111, 1'b0, 0);
      in_valid = 1'b1;
      in_a = 16'h0000;
      in_b = 16'h0000;
      in_cin = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         @(posedge clk);
         #1;
      end
      check("bp_valid", 64'(out_valid), 64'd1);
      a0 = acc_cnt;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("bp_valid_held", 64'(out_valid), 64'd1);
      check("bp_sum_held", 64'(out_sum), 64'hBCDE);
      check("bp_no_accept", 64'(acc_cnt), 64'(a0));
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_idle_ready", 64'(in_ready), 64'd1);
      check("bp_idle_valid", 64'(out_valid), 64'd0);
      check("bp_result", 64'(last_sum), 64'hBCDE);

      drive_op(16'h8000, 16'h8000, 1'b0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_sum", 64'(out_sum), 64'd0);
      check("mid_rst_carry", 64'(out_carry), 64'd0);
      r0 = res_cnt;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check("mid_rst_no_result", 64'(res_cnt), 64'(r0));
      drive_op(16'h0001, 16'h0002, 1'b0, 0);
      wait_results(res_cnt + 1);
      check("post_rst_sum", 64'(last_sum), 64'h0003);

      r0 = res_cnt;
      drive_op(16'h1111, 16'h2222, 1'b0, 1);
      drive_op(16'h0F0F, 16'hF0F0, 1'b1, 1);
      drive_op(16'h7FFF, 16'h7FFF, 1'b1, 0);
      wait_results(r0 + 3);
      n = res_cyc.size();
      if (n >= 3) begin
         check("b2b_gap1", 64'(res_cyc[n-2] - res_cyc[n-3]), 64'(NIB + 2));
         check("b2b_gap2", 64'(res_cyc[n-1] - res_cyc[n-2]), 64'(NIB + 2));
      end else begin
         check("b2b_count", 64'(n), 64'd3);
      end
      check("b2b_last", 64'({last_carry, last_sum}), 64'h0FFFF);

      rand_ready = 1;
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         drive_op(W'($urandom), W'($urandom), 1'($urandom), 0);
      end
      in_valid = 1'b0;
      rand_ready = 0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (!pending && exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      check("result_count", 64'(res_cnt), 64'(acc_cnt - dropped));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
